force_overlay_bank: RTL

Multi-channel force/release overlay for testbench-visible signals. It sits between each design driver and its consumers. A command port forces or releases an arbitrary bit subset of any channel, so forced bits replace the driven value and unforced bits pass through. It generalises single-signal, whole-vector force/release to `NCH` channels of `W` bits, with masked (partial) release, a release-all sweep, and optional variable-style hold-after-release.

---
 rtl/force_overlay_bank.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/force_overlay_bank.sv
// Multi-channel force/release overlay: forced bits replace the driven value, the rest pass through.
// Optional variable-style hold-after-release is built when FORCE_OVERLAY_HOLD_EN is defined.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | accepting commands; cmd_ready high (unless rst)
//   S_SWEEP | RELEASE_ALL in progress; channel r_sc released each cycle
module force_overlay_bank #(
    parameter int W   = 32,
    parameter int NCH = 4,
    parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH*W-1:0]   drv_i,
    output logic [NCH*W-1:0]   sig_o,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [CHW-1:0]     cmd_ch,
    input  logic [W-1:0]       cmd_mask,
    input  logic [W-1:0]       cmd_data,
    output logic [NCH-1:0]     forced_o,
    output logic               err_o
);

    localparam logic [1:0]     OP_FORCE   = 2'b00;
    localparam logic [1:0]     OP_RELEASE = 2'b01;
    localparam logic [1:0]     OP_RELALL  = 2'b10;
    localparam logic [1:0]     OP_RSVD    = 2'b11;
    localparam logic [CHW:0]   NCH_L      = (CHW+1)'(NCH);
    localparam logic [CHW-1:0] SC_LAST    = CHW'(NCH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t                     r_state, w_state_n;
    logic [CHW-1:0]             r_sc, w_sc_n;
    logic [NCH-1:0][W-1:0]      r_fmask, w_fmask_n;
    logic [NCH-1:0][W-1:0]      r_fval, w_fval_n;
    logic                       r_err, w_err_n;
    logic                       w_xfer;
    logic                       w_bad;
    logic [NCH-1:0][W-1:0]      w_fm;
    logic [NCH-1:0][W-1:0]      w_under;

`ifdef FORCE_OVERLAY_HOLD_EN
    logic [NCH-1:0][W-1:0]      r_hmask, w_hmask_n;
    logic [NCH-1:0][W-1:0]      r_hval, w_hval_n;
    logic [NCH*W-1:0]           r_drv_q;
`endif

    assign cmd_ready = ~rst & (r_state == S_IDLE);
    assign w_xfer    = cmd_valid & cmd_ready;
    assign w_bad     = (cmd_op == OP_RSVD) |
                       ((cmd_op != OP_RELALL) & ({1'b0, cmd_ch} >= NCH_L));
    assign err_o     = r_err;

    // Overlay is gated by rst so consumers see drv_i even before the first reset edge.
    always_comb begin
        w_fm    = '0;
        w_under = '0;
        sig_o   = '0;
        for (int c = 0; c < NCH; c++) begin
            w_fm[c] = rst ? '0 : r_fmask[c];
`ifdef FORCE_OVERLAY_HOLD_EN
            w_under[c] = rst ? drv_i[c*W +: W]
                             : ((r_hmask[c] & r_hval[c]) | (~r_hmask[c] & drv_i[c*W +: W]));
`else
            w_under[c] = drv_i[c*W +: W];
`endif
            sig_o[c*W +: W] = (w_fm[c] & r_fval[c]) | (~w_fm[c] & w_under[c]);
        end
    end

    always_comb begin
        forced_o = '0;
        for (int c = 0; c < NCH; c++) begin
            forced_o[c] = |r_fmask[c];
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_sc_n    = r_sc;
        w_fmask_n = r_fmask;
        w_fval_n  = r_fval;
        w_err_n   = 1'b0;
`ifdef FORCE_OVERLAY_HOLD_EN
        w_hval_n  = r_hval;
        w_hmask_n = '0;
        // A held bit lets go as soon as its driver moves.
        for (int c = 0; c < NCH; c++) begin
            w_hmask_n[c] = r_hmask[c] & ~(drv_i[c*W +: W] ^ r_drv_q[c*W +: W]);
        end
`endif
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (w_bad) begin
                        w_err_n = 1'b1;
                    end else if (cmd_op == OP_RELALL) begin
                        w_state_n = S_SWEEP;
                        w_sc_n    = '0;
                    end else begin
                        for (int c = 0; c < NCH; c++) begin
                            if (cmd_ch == CHW'(c)) begin
                                if (cmd_op == OP_FORCE) begin
                                    w_fmask_n[c] = r_fmask[c] | cmd_mask;
                                    w_fval_n[c]  = (r_fval[c] & ~cmd_mask) | (cmd_data & cmd_mask);
`ifdef FORCE_OVERLAY_HOLD_EN
                                    w_hmask_n[c] = w_hmask_n[c] & ~cmd_mask;
`endif
                                end else begin
                                    w_fmask_n[c] = r_fmask[c] & ~cmd_mask;
`ifdef FORCE_OVERLAY_HOLD_EN
                                    w_hmask_n[c] = w_hmask_n[c] | (r_fmask[c] & cmd_mask);
                                    w_hval_n[c]  = (r_hval[c] & ~(r_fmask[c] & cmd_mask)) |
                                                   (r_fval[c] &   r_fmask[c] & cmd_mask);
`endif
                                end
                            end
                        end
                    end
                end
            end
            S_SWEEP: begin
                for (int c = 0; c < NCH; c++) begin
                    if (r_sc == CHW'(c)) begin
                        w_fmask_n[c] = '0;
`ifdef FORCE_OVERLAY_HOLD_EN
                        w_hmask_n[c] = w_hmask_n[c] | r_fmask[c];
                        w_hval_n[c]  = (r_hval[c] & ~r_fmask[c]) | (r_fval[c] & r_fmask[c]);
`endif
                    end
                end
                if (r_sc == SC_LAST) begin
                    w_state_n = S_IDLE;
                    w_sc_n    = '0;
                end else begin
                    w_sc_n = r_sc + 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_sc_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sc    <= '0;
            r_fmask <= '0;
            r_fval  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_sc    <= w_sc_n;
            r_fmask <= w_fmask_n;
            r_fval  <= w_fval_n;
            r_err   <= w_err_n;
        end
    end

`ifdef FORCE_OVERLAY_HOLD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hmask <= '0;
            r_hval  <= '0;
            r_drv_q <= '0;
        end else begin
            r_hmask <= w_hmask_n;
            r_hval  <= w_hval_n;
            r_drv_q <= drv_i;
        end
    end
`endif

endmodule
